// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared definitions for the FIFO write-port arbiter.
//   arb_state_e : FSM state encoding (ST_IDLE, ST_BURST)
//   clog2       : ceiling log2, used to size owner, beat and stall counters
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
// Searches req_i starting at last_owner_i + 1 and wrapping around; the first
// asserted bit wins.
//   req_i        : per-requester request
//   last_owner_i : index of the most recent grantee
//   gnt_o        : one-hot winner (all zero when req_i == 0)
//   idx_o        : index of the winner (0 when req_i == 0)
module rr_pick #(
    parameter int unsigned num_req = 4,
    parameter int unsigned owner_w = 2
) (
    input  logic [num_req-1:0] req_i,
    input  logic [owner_w-1:0] last_owner_i,
    output logic [num_req-1:0] gnt_o,
    output logic [owner_w-1:0] idx_o
);

    logic               found;
    logic [owner_w-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        // k runs 1..num_req so the previous owner is considered last.
        for (int unsigned k = 1; k <= num_req; k++) begin
            cand = owner_w'((32'(last_owner_i) + k) % num_req);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one async-FIFO write port among
// num_req requesters in the write-clock domain. Each grant covers a burst of
// up to max_burst words; writes stall while the FIFO is full.
//
// Optional build macro FIFO_WR_ARB_STALL_RELEASE_EN: releases a grant after
// stall_limit consecutive cycles of full while the owner still requests.
//
// Ports:
//   clk       : write-side clock
//   reset_n   : asynchronous active-low reset
//   req       : per-requester level request, held while its word is valid
//   req_data  : packed words, requester i at [i*word_width +: word_width]
//   full      : FIFO full flag (write-domain)
//   gnt       : registered one-hot grant, zero when idle
//   wr        : FIFO write strobe
//   fifo_data : word to FIFO data_in
//   owner     : index of the current grantee (valid while gnt != 0)
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned num_req     = 4,
    parameter int unsigned word_width  = 8,
    parameter int unsigned max_burst   = 4,
    parameter int unsigned stall_limit = 8,
    localparam int unsigned OwnerW     = (clog2(num_req) > 0) ? clog2(num_req) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [num_req-1:0]            req,
    input  logic [num_req*word_width-1:0] req_data,
    input  logic                          full,
    output logic [num_req-1:0]            gnt,
    output logic                          wr,
    output logic [word_width-1:0]         fifo_data,
    output logic [OwnerW-1:0]             owner
);

    localparam int unsigned BeatW = clog2(max_burst + 1);
    localparam logic [BeatW-1:0] BeatLast = BeatW'(max_burst - 1);

    arb_state_e          state_q, state_d;
    logic [num_req-1:0]  gnt_q, gnt_d;
    logic [OwnerW-1:0]   owner_q, owner_d;
    logic [OwnerW-1:0]   last_owner_q, last_owner_d;
    logic [BeatW-1:0]    beat_cnt_q, beat_cnt_d;

    logic [num_req-1:0]  pick_gnt;
    logic [OwnerW-1:0]   pick_idx;
    logic                req_own;
    logic                accept;

`ifdef FIFO_WR_ARB_STALL_RELEASE_EN
    localparam int unsigned StallW = clog2(stall_limit + 1);
    localparam logic [StallW-1:0] StallLast = StallW'(stall_limit - 1);

    logic [StallW-1:0]   stall_cnt_q, stall_cnt_d;
`else
    // stall_limit only has an effect in the stall-release build.
    logic unused_stall_cfg;
    assign unused_stall_cfg = ^32'(stall_limit);
`endif

    rr_pick #(
        .num_req (num_req),
        .owner_w (OwnerW)
    ) u_rr_pick (
        .req_i        (req),
        .last_owner_i (last_owner_q),
        .gnt_o        (pick_gnt),
        .idx_o        (pick_idx)
    );

    assign req_own = req[owner_q];
    assign accept  = (state_q == ST_BURST) && req_own && !full;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= OwnerW'(num_req - 1);
            beat_cnt_q   <= '0;
`ifdef FIFO_WR_ARB_STALL_RELEASE_EN
            stall_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
`ifdef FIFO_WR_ARB_STALL_RELEASE_EN
            stall_cnt_q  <= stall_cnt_d;
`endif
        end
    end

    // Next-state logic. Every release goes through ST_IDLE, which gives the
    // one-cycle bubble before the next grant.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
`ifdef FIFO_WR_ARB_STALL_RELEASE_EN
        stall_cnt_d  = stall_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d      = ST_BURST;
                    gnt_d        = pick_gnt;
                    owner_d      = pick_idx;
                    last_owner_d = pick_idx;
                    beat_cnt_d   = '0;
`ifdef FIFO_WR_ARB_STALL_RELEASE_EN
                    stall_cnt_d  = '0;
`endif
                end
            end
            ST_BURST: begin
                if (!req_own) begin
                    // Requester dropped: end the burst without a write.
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + BeatW'(1);
`ifdef FIFO_WR_ARB_STALL_RELEASE_EN
                    stall_cnt_d = '0;
`endif
                    if (beat_cnt_q == BeatLast) begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end
`ifdef FIFO_WR_ARB_STALL_RELEASE_EN
                else begin
                    // Stalled on full with the owner still requesting.
                    if (stall_cnt_q == StallLast) begin
                        state_d     = ST_IDLE;
                        gnt_d       = '0;
                        stall_cnt_d = '0;
                    end else begin
                        stall_cnt_d = stall_cnt_q + StallW'(1);
                    end
                end
`endif
            end
        endcase
    end

    // Outputs.
    always_comb begin
        wr        = 1'b0;
        fifo_data = '0;
        if (state_q == ST_BURST) begin
            wr        = accept;
            fifo_data = req_data[32'(owner_q) * word_width +: word_width];
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;

endmodule
